mdu_unit: RTL and testbench
===========================

# mdu_unit

Parametrised multiply/divide unit for the execute stage, alongside the combinational ALU. It accepts MULT/MULTU/DIV/DIVU, holds the results in internal HI/LO registers for a fixed, configurable number of cycles, and reports `busy` so the hazard unit can stall. It also handles MTHI/MTLO writes and MFHI/MFLO reads.

## Interface
Parameters:
- `WIDTH`, 32: operand and HI/LO width.
- `MUL_CYCLES`, 5: busy cycles for MULT/MULTU (≥1).
- `DIV_CYCLES`, 10: busy cycles for DIV/DIVU (≥1).

Ports:
- `clk`  in  1: single clock, all state updates on the rising edge.
- `reset`  in  1: synchronous, active-low (0 = reset), sampled on the `clk` rising edge.
- `start`  in  1: launch or execute `mdu_op` this cycle.
- `mdu_op`  in  4: operation code; encodings live in `mdu_pkg`.
- `SA`  in  WIDTH: rs operand; dividend for divides.
- `SB`  in  WIDTH: rt operand; divisor for divides.
- `busy`  out  1: a multi-cycle operation is in flight.
- `hi`  out  WIDTH: HI register.
- `lo`  out  WIDTH: LO register.
- `MDUOut`  out  WIDTH: combinational result. HI for MFHI, LO for MFLO, 0 otherwise.

## Operation
Op codes:
- 0000 NONE
- 0001 MULT
- 0010 MULTU
- 0011 DIV
- 0100 DIVU
- 0101 MTHI
- 0110 MTLO
- 0111 MFHI
- 1000 MFLO
- Any other code: treated as NONE.

Behaviour:
- Two-state FSM, IDLE and RUN, plus a down-counter `cnt` wide enough for max(MUL_CYCLES, DIV_CYCLES).
- IDLE with `start` and a MULT/MULTU/DIV/DIVU code:
  - Capture the result into pending registers `p_hi`/`p_lo`.
  - Load `cnt` with MUL_CYCLES or DIV_CYCLES.
  - Go to RUN.
- RUN: decrement `cnt` every cycle. When `cnt` reaches 1, copy `p_hi`/`p_lo` into `hi`/`lo` and return to IDLE.
- MTHI/MTLO in IDLE: write `hi` or `lo` from SA in one cycle. No busy.
- MFHI/MFLO: purely combinational; state is unchanged.
- `start` is ignored while `busy`=1, and any op code is ignored then. The pipeline must stall.
- Multiply results: MULT forms the signed 2·WIDTH-bit product; MULTU the unsigned one. `{hi,lo}` = product.
- Divide results: DIV uses truncating signed division, so the remainder takes the sign of the dividend. LO = quotient, HI = remainder. DIVU is unsigned.
- Divide by zero (SB = 0): the operation still runs its full DIV_CYCLES. At completion, `hi` = SA and `lo` = all ones.
- Signed overflow (DIV with SA = most-negative, SB = −1): `lo` = SA, `hi` = 0.

## Timing
- Reset: `hi`=0, `lo`=0, `busy`=0, FSM=IDLE, `cnt`=0, pending registers cleared. `MDUOut` follows from these values.
- A reset sampled mid-operation aborts the operation; no HI/LO update occurs.
- Start in cycle t (sampled at edge t):
  - `busy`=1 during cycles t+1 … t+N.
  - New `hi`/`lo` are visible from cycle t+N+1, the same cycle `busy` drops.
  - N = MUL_CYCLES or DIV_CYCLES.
- Back-to-back: a new `start` is accepted in cycle t+N+1.
- MTHI/MTLO: the value is visible in `hi`/`lo` the cycle after `start`.
- MFHI/MFLO issued while `busy`=1 returns the old HI/LO. The hazard unit must stall it.
- `busy` is a registered output; it has no combinational path from `start`.

## Structure
- `mdu_pkg`: op-code localparams (MDU_NONE … MDU_MFLO) and the FSM state encoding, shared with the controller and hazard unit.
- Sub-module `mdu_compute`: combinational computation of {hi,lo} from (op, SA, SB), including the divide-by-zero and overflow rules.
- `mdu_unit` holds the FSM, counter, pending and architectural registers, and the output mux.

## Test plan
- MULT, SA=0xFFFFFFFE (−2), SB=3 → `busy` high for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands → hi=0x00000002, lo=0xFFFFFFFA.
- DIV, SA=−7, SB=2 → after 10 busy cycles lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1). DIVU, SA=7, SB=2 → lo=3, hi=1.
- DIVU, SA=0x1234, SB=0 → hi=0x1234, lo=0xFFFFFFFF. DIV, SA=0x80000000, SB=0xFFFFFFFF → lo=0x80000000, hi=0.
- MULT in flight; at busy cycle 2 assert `start` with MTHI, SA=0xAAAA → MTHI ignored, hi/lo = MULT result.
- MTLO, SA=0x55 → lo=0x55 the next cycle, busy stays 0. MFLO in the same following cycle → MDUOut=0x55.
- DIV in flight; pull `reset` low for one edge at busy cycle 4 → busy=0, hi=lo=0, no late update.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes,
// FSM state encoding and op-class helpers.
package mdu_pkg;

  localparam logic [3:0] MDU_NONE  = 4'b0000;
  localparam logic [3:0] MDU_MULT  = 4'b0001;
  localparam logic [3:0] MDU_MULTU = 4'b0010;
  localparam logic [3:0] MDU_DIV   = 4'b0011;
  localparam logic [3:0] MDU_DIVU  = 4'b0100;
  localparam logic [3:0] MDU_MTHI  = 4'b0101;
  localparam logic [3:0] MDU_MTLO  = 4'b0110;
  localparam logic [3:0] MDU_MFHI  = 4'b0111;
  localparam logic [3:0] MDU_MFLO  = 4'b1000;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } mdu_state_t;

  function automatic logic is_mul(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU);
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_if.sv
// Execute-stage <-> MDU bundle: start/mdu_op/SA/SB in,
// busy/hi/lo/MDUOut out. master = pipeline, slave = MDU.
interface mdu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       mdu_op;
  logic [WIDTH-1:0] SA;
  logic [WIDTH-1:0] SB;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] MDUOut;

  modport master (
    output start, mdu_op, SA, SB,
    input  busy, hi, lo, MDUOut
  );

  modport slave (
    input  start, mdu_op, SA, SB,
    output busy, hi, lo, MDUOut
  );
endinterface

// File: rtl/mdu_compute.sv
// Combinational {hi,lo} for MULT/MULTU/DIV/DIVU.
// Ports: op, sa, sb in; hi_res, lo_res out (0 for other ops).
module mdu_compute
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] sa,
  input  logic [WIDTH-1:0] sb,
  output logic [WIDTH-1:0] hi_res,
  output logic [WIDTH-1:0] lo_res
);

  localparam logic [WIDTH-1:0] ONES = '1;
  localparam logic [WIDTH-1:0] MINV =
    {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0]        prod_u;
  logic signed [WIDTH-1:0]   quot_s;
  logic signed [WIDTH-1:0]   rem_s;
  logic [WIDTH-1:0]          quot_u;
  logic [WIDTH-1:0]          rem_u;
  logic                      div_zero;
  logic                      div_ovf;

  assign prod_s =
    $signed({{WIDTH{sa[WIDTH-1]}}, sa}) *
    $signed({{WIDTH{sb[WIDTH-1]}}, sb});
  assign prod_u =
    {{WIDTH{1'b0}}, sa} * {{WIDTH{1'b0}}, sb};

  assign div_zero = (sb == '0);
  assign div_ovf  = (sa == MINV) && (sb == ONES);

  // Divide inputs are forced to safe values on the
  // special cases, whose results are muxed in below.
  logic [WIDTH-1:0] dsb;
  assign dsb = (div_zero || div_ovf) ? WIDTH'(1) : sb;

  assign quot_s = $signed(sa) / $signed(dsb);
  assign rem_s  = $signed(sa) % $signed(dsb);
  assign quot_u = sa / dsb;
  assign rem_u  = sa % dsb;

  always_comb begin
    hi_res = '0;
    lo_res = '0;
    unique case (1'b1)
      (op == MDU_MULT): begin
        {hi_res, lo_res} = prod_s;
      end
      (op == MDU_MULTU): begin
        {hi_res, lo_res} = prod_u;
      end
      (op == MDU_DIV): begin
        if (div_zero) begin
          hi_res = sa;
          lo_res = ONES;
        end else if (div_ovf) begin
          hi_res = '0;
          lo_res = sa;
        end else begin
          hi_res = rem_s;
          lo_res = quot_s;
        end
      end
      (op == MDU_DIVU): begin
        if (div_zero) begin
          hi_res = sa;
          lo_res = ONES;
        end else begin
          hi_res = rem_u;
          lo_res = quot_u;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
// Ports: clk, reset (sync, active-low), bus (mdu_if.slave).
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic  clk,
  input  logic  reset,
  mdu_if.slave  bus
);

  localparam int MAXC =
    (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MUL_N = CW'(MUL_CYCLES);
  localparam logic [CW-1:0] DIV_N = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] ONE_N = CW'(1);

  mdu_state_t       state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] hi_q, hi_n;
  logic [WIDTH-1:0] lo_q, lo_n;
  logic [WIDTH-1:0] p_hi, p_hi_n;
  logic [WIDTH-1:0] p_lo, p_lo_n;
  logic [WIDTH-1:0] res_hi, res_lo;

  mdu_compute #(.WIDTH(WIDTH)) u_compute (
    .op     (bus.mdu_op),
    .sa     (bus.SA),
    .sb     (bus.SB),
    .hi_res (res_hi),
    .lo_res (res_lo)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      p_hi  <= '0;
      p_lo  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      hi_q  <= hi_n;
      lo_q  <= lo_n;
      p_hi  <= p_hi_n;
      p_lo  <= p_lo_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    hi_n    = hi_q;
    lo_n    = lo_q;
    p_hi_n  = p_hi;
    p_lo_n  = p_lo;
    unique case (state)
      ST_IDLE: begin
        if (bus.start) begin
          unique case (1'b1)
            is_mul(bus.mdu_op): begin
              p_hi_n  = res_hi;
              p_lo_n  = res_lo;
              cnt_n   = MUL_N;
              state_n = ST_RUN;
            end
            is_div(bus.mdu_op): begin
              p_hi_n  = res_hi;
              p_lo_n  = res_lo;
              cnt_n   = DIV_N;
              state_n = ST_RUN;
            end
            (bus.mdu_op == MDU_MTHI): hi_n = bus.SA;
            (bus.mdu_op == MDU_MTLO): lo_n = bus.SA;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        cnt_n = cnt - ONE_N;
        // Last busy cycle: commit so HI/LO and busy
        // change together on the next edge.
        if (cnt == ONE_N) begin
          hi_n    = p_hi;
          lo_n    = p_lo;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign bus.busy = (state == ST_RUN);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

  always_comb begin
    bus.MDUOut = '0;
    if (bus.mdu_op == MDU_MFHI) bus.MDUOut = hi_q;
    if (bus.mdu_op == MDU_MFLO) bus.MDUOut = lo_q;
  end

endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit: directed cases plus
// randomized ops checked against an arithmetic model.
module tb_mdu_unit;
  import mdu_pkg::*;

  localparam int W  = 32;
  localparam int MC = 5;
  localparam int DC = 10;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  mdu_if #(.WIDTH(W)) bus ();

  mdu_unit #(
    .WIDTH      (W),
    .MUL_CYCLES (MC),
    .DIV_CYCLES (DC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          n;
    string       tag;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_hi   = '0;
  logic [31:0] m_lo   = '0;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h",
               name, act, exp);
    end
  endtask

  // Reference: {hi,lo} from plain integer arithmetic.
  function automatic logic [63:0] ref_res(
    logic [3:0] op, logic [31:0] a, logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    int              q, r;
    sa = longint'(int'(a));
    sb = longint'(int'(b));
    ua = a;
    ub = b;
    case (op)
      MDU_MULT:  return 64'(sa * sb);
      MDU_MULTU: return 64'(ua * ub);
      MDU_DIV: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          return {32'h0, a};
        q = int'(a) / int'(b);
        r = int'(a) % int'(b);
        return {r, q};
      end
      MDU_DIVU: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return 64'h0;
    endcase
  endfunction

  // Monitor: each busy->idle transition retires one entry.
  int   bc = 0;
  logic pb = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      bc = 0;
      pb = 1'b0;
    end else begin
      if (bus.busy) begin
        bc++;
      end else if (pb) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=1 required=0");
        end else begin
          e = sbq.pop_front();
          chk({e.tag, " hi"}, bus.hi, e.hi);
          chk({e.tag, " lo"}, bus.lo, e.lo);
          chk({e.tag, " busy_cycles"}, bc, e.n);
        end
        bc = 0;
      end
      pb = bus.busy;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(string tag);
    int k;
    k = 0;
    while (bus.busy && k < 40) begin
      step();
      k++;
    end
    chk({tag, " idle_timeout"}, bus.busy, 0);
  endtask

  function automatic bit is_md(logic [3:0] op);
    return op >= MDU_MULT && op <= MDU_DIVU;
  endfunction

  task automatic run_op(logic [3:0] op, logic [31:0] a,
                        logic [31:0] b, string tag);
    logic [63:0] r;
    bus.start  = 1'b1;
    bus.mdu_op = op;
    bus.SA     = a;
    bus.SB     = b;
    #1;
    if (op == MDU_MFHI)
      chk({tag, " mdu_out"}, bus.MDUOut, m_hi);
    else if (op == MDU_MFLO)
      chk({tag, " mdu_out"}, bus.MDUOut, m_lo);
    else
      chk({tag, " mdu_out"}, bus.MDUOut, 0);
    r = ref_res(op, a, b);
    if (is_md(op))
      sbq.push_back('{r[63:32], r[31:0],
                      (op <= MDU_MULTU) ? MC : DC, tag});
    step();
    bus.start  = 1'b0;
    bus.mdu_op = MDU_NONE;
    if (is_md(op)) begin
      chk({tag, " busy_rise"}, bus.busy, 1);
      wait_idle(tag);
      m_hi = r[63:32];
      m_lo = r[31:0];
    end else begin
      if (op == MDU_MTHI) m_hi = a;
      if (op == MDU_MTLO) m_lo = a;
      chk({tag, " busy"}, bus.busy, 0);
      chk({tag, " hi"}, bus.hi, m_hi);
      chk({tag, " lo"}, bus.lo, m_lo);
    end
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [63:0] r;
    logic [3:0]  op;
    bus.start  = 1'b0;
    bus.mdu_op = MDU_NONE;
    bus.SA     = '0;
    bus.SB     = '0;
    repeat (2) step();
    chk("reset hi", bus.hi, 0);
    chk("reset lo", bus.lo, 0);
    chk("reset busy", bus.busy, 0);
    chk("reset mdu_out", bus.MDUOut, 0);
    reset = 1'b1;
    step();

    run_op(MDU_MULT,  32'hFFFF_FFFE, 32'd3, "mult");
    run_op(MDU_MULTU, 32'hFFFF_FFFE, 32'd3, "multu");
    run_op(MDU_DIV,   32'hFFFF_FFF9, 32'd2, "div");
    run_op(MDU_DIVU,  32'd7, 32'd2, "divu");
    run_op(MDU_DIVU,  32'h1234, 32'd0, "divu_zero");
    run_op(MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF,
           "div_ovf");
    run_op(MDU_DIV,   32'h0000_0042, 32'd0, "div_zero");
    run_op(MDU_MTLO,  32'h55, 32'd0, "mtlo");
    run_op(MDU_MFLO,  32'd0, 32'd0, "mflo");
    run_op(MDU_MTHI,  32'h77, 32'd0, "mthi");
    run_op(MDU_MFHI,  32'd0, 32'd0, "mfhi");

    // Ops issued while busy: MFHI sees old HI, MTHI and
    // a second MULT are ignored.
    r = ref_res(MDU_MULT, 32'd1000, 32'hFFFF_FFF0);
    bus.start  = 1'b1;
    bus.mdu_op = MDU_MULT;
    bus.SA     = 32'd1000;
    bus.SB     = 32'hFFFF_FFF0;
    sbq.push_back('{r[63:32], r[31:0], MC, "busy_ign"});
    step();
    bus.mdu_op = MDU_MFHI;
    #1;
    chk("mfhi_busy mdu_out", bus.MDUOut, m_hi);
    step();
    bus.mdu_op = MDU_MTHI;
    bus.SA     = 32'hAAAA;
    step();
    bus.mdu_op = MDU_MULT;
    bus.SA     = 32'd3;
    bus.SB     = 32'd3;
    step();
    bus.start  = 1'b0;
    bus.mdu_op = MDU_NONE;
    wait_idle("busy_ign");
    m_hi = r[63:32];
    m_lo = r[31:0];
    step();
    chk("busy_ign hold hi", bus.hi, m_hi);
    chk("busy_ign hold lo", bus.lo, m_lo);

    // Reset mid-divide aborts with no late commit.
    bus.start  = 1'b1;
    bus.mdu_op = MDU_DIV;
    bus.SA     = 32'd100;
    bus.SB     = 32'd7;
    step();
    bus.start  = 1'b0;
    bus.mdu_op = MDU_NONE;
    repeat (3) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    m_hi = '0;
    m_lo = '0;
    chk("abort busy", bus.busy, 0);
    chk("abort hi", bus.hi, 0);
    chk("abort lo", bus.lo, 0);
    repeat (DC + 2) step();
    chk("abort late hi", bus.hi, 0);
    chk("abort late lo", bus.lo, 0);
    chk("abort late busy", bus.busy, 0);

    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      run_op(op, rnd_val(), rnd_val(),
             $sformatf("rnd%0d_op%0d", i, op));
    end

    repeat (3) step();
    chk("scoreboard empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
